// File: rtl/dmc_line_filler.sv
// dmc_line_filler: miss handler and line-fill controller for a 32-line x 16-byte direct-mapped cache.
// Optional fetch watchdog is compiled in when DMC_FILL_TIMEOUT_EN is defined.
module dmc_line_filler #(
  parameter int AW      = 24,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          hit,
  output logic          cpu_ready,
  output logic          busy,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [AW-1:0] fill_addr,
  output logic [127:0]  line,
  output logic          wr,
  output logic          fill_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [1:0]      r_beat;
  logic [127:0]    r_line;
  logic [AW-1:0]   r_base;
  logic            w_miss;
  logic            w_beat_done;
  logic            w_timeout;

  // Memory handshake: mem_req/mem_addr stay stable until a cycle with mem_req & mem_ack;
  // that cycle transfers one beat, and mem_ack without mem_req carries no data.
  assign w_miss      = cpu_req & ~hit;
  assign w_beat_done = (r_state == S_FETCH) & mem_ack;

`ifdef DMC_FILL_TIMEOUT_EN
  logic [7:0] r_wdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= 8'd0;
    end else if ((r_state != S_FETCH) || mem_ack) begin
      r_wdog <= 8'd0;
    end else begin
      r_wdog <= r_wdog + 8'd1;
    end
  end

  assign w_timeout = (r_state == S_FETCH) & ~mem_ack & (r_wdog == 8'(TIMEOUT));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_miss) w_next_state = S_FETCH;
      S_FETCH: begin
        if (w_beat_done && (r_beat == 2'd3)) begin
          w_next_state = S_WRITE;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_WRITE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Base is stored line-aligned, so beat addresses can never leave the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= 2'd0;
      r_line <= 128'd0;
      r_base <= '0;
    end else if ((r_state == S_IDLE) && w_miss) begin
      r_base <= cpu_addr & {{(AW-4){1'b1}}, 4'h0};
      r_beat <= 2'd0;
    end else if (w_beat_done) begin
      r_line[{r_beat, 5'd0} +: 32] <= mem_rdata;
      r_beat                       <= r_beat + 2'd1;
    end
  end

  assign cpu_ready = (r_state == S_IDLE) & cpu_req & hit;
  assign busy      = (r_state != S_IDLE);
  assign mem_req   = (r_state == S_FETCH);
  assign mem_addr  = r_base | {{(AW-4){1'b0}}, r_beat, 2'b00};
  assign fill_addr = r_base;
  assign line      = r_line;
  assign wr        = (r_state == S_WRITE);
  assign fill_err  = w_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmc_line_filler.sv
// Bench for dmc_line_filler: cache/memory environment, directed fills and randomized accesses
// scored against a direct-mapped cache reference model.
module tb_dmc_line_filler;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          hit;
  logic          cpu_ready;
  logic          busy;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic [AW-1:0] fill_addr;
  logic [127:0]  line;
  logic          wr;
  logic          fill_err;
  logic [1:0]    dbg_state;

  dmc_line_filler #(.AW(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .hit(hit),
    .cpu_ready(cpu_ready), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fill_addr(fill_addr), .line(line),
    .wr(wr), .fill_err(fill_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int ack_mode = 0;
  int stall_cnt = 0;
  int tb_beats = 0;
  int err_seen = 0;
  bit allow_abort = 1'b0;

  logic [151:0] fill_q[$];
  logic [23:0]  ready_q[$];

  // Environment cache: captures whatever the DUT writes.
  logic [31:0] env_valid = '0;
  logic [14:0] env_tag[32];
  assign hit = env_valid[cpu_addr[8:4]] && (env_tag[cpu_addr[8:4]] == cpu_addr[23:9]);

  always @(posedge clk) begin
    if (rst_n && wr) begin
      env_valid[fill_addr[8:4]] <= 1'b1;
      env_tag[fill_addr[8:4]]   <= fill_addr[23:9];
    end
  end

  // Reference model state.
  logic [31:0] ref_valid = '0;
  logic [14:0] ref_tag[32];

  task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s: got event expected none/other", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    logic [31:0] k;
    k = 32'(a[3:2]) + 32'd1;
    if (a[23:4] == 20'h01234) return 32'h11111111 * k;
    return {a[15:0] ^ 16'hA5C3, a[23:8]} ^ 32'h5EED1234;
  endfunction

  function automatic logic [127:0] line_of(input logic [23:0] base);
    logic [127:0] l;
    for (int b = 0; b < 4; b++) l[32*b +: 32] = mem_word(base + 24'(4*b));
    return l;
  endfunction

  task automatic predict(input logic [23:0] a, output bit miss);
    logic [4:0]  idx;
    logic [23:0] base;
    idx  = a[8:4];
    miss = !(ref_valid[idx] && (ref_tag[idx] == a[23:9]));
    if (miss) begin
      base = {a[23:4], 4'h0};
      fill_q.push_back({base, line_of(base)});
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[23:9];
    end
  endtask

  // Memory responder.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: mem_ack = mem_req;
        1: begin
          if (mem_req) begin
            stall_cnt++;
            mem_ack = (stall_cnt % 3 == 0);
          end else begin
            stall_cnt = 0;
            mem_ack   = 1'b0;
          end
        end
        2: mem_ack = mem_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
        default: mem_ack = 1'b0;
      endcase
      mem_rdata = mem_req ? mem_word(mem_addr) : $urandom;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit           prev_pend;
    bit           prev_wr;
    logic [23:0]  prev_addr;
    logic [151:0] e;
    logic [23:0]  eb;
    prev_pend = 1'b0;
    prev_wr   = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
        prev_wr   = 1'b0;
      end else begin
        if (prev_pend && !allow_abort)
          check("req_hold", {mem_req, mem_addr}, {1'b1, prev_addr});
        if (mem_req && mem_ack) begin
          if (fill_q.size() == 0) fail_now("unexpected_beat");
          else begin
            e  = fill_q[0];
            eb = e[151:128] + 24'(4 * tb_beats);
            check("beat_addr", mem_addr, eb);
          end
          tb_beats++;
        end
        if (wr) begin
          check("wr_single", prev_wr, 1'b0);
          check("wr_busy", busy, 1'b1);
          if (fill_q.size() == 0) fail_now("unexpected_wr");
          else begin
            e = fill_q.pop_front();
            check("fill_addr", fill_addr, e[151:128]);
            check("line", line, e[127:0]);
            check("beats_before_wr", 152'(tb_beats), 152'(4));
          end
          tb_beats = 0;
        end
        if (cpu_ready) begin
          check("ready_not_busy", busy, 1'b0);
          if (ready_q.size() == 0) fail_now("unexpected_ready");
          else check("ready_addr", cpu_addr, ready_q.pop_front());
        end
        if (fill_err) err_seen++;
        prev_pend = mem_req && !mem_ack;
        prev_addr = mem_addr;
        prev_wr   = wr;
      end
    end
  end

  task automatic do_access(input logic [23:0] a, input bit withdraw);
    bit miss;
    bit got;
    predict(a, miss);
    if (!(withdraw && miss)) ready_q.push_back(a);
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = a;
    got = 1'b0;
    if (withdraw && miss) begin
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (busy) begin got = 1'b1; break; end
      end
      if (!got) fail_now("busy_timeout");
      @(posedge clk); #1;
      cpu_req = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 500; n++) begin
        @(negedge clk);
        if (!busy) begin got = 1'b1; break; end
      end
      if (!got) fail_now("withdraw_timeout");
    end else begin
      for (int n = 0; n < 500; n++) begin
        @(negedge clk);
        if (cpu_ready) begin got = 1'b1; break; end
      end
      if (!got) fail_now("ready_timeout");
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // Cycle-exact miss with back-to-back acks; optional address churn during FETCH.
  task automatic directed_miss(input logic [23:0] a, input bit churn, input logic [127:0] exp_line);
    bit          miss;
    int          wr_cyc;
    int          rdy_cyc;
    int          nacks;
    logic [23:0] seen[4];
    logic [23:0] base;
    logic [127:0] wline;
    logic [23:0] wfa;
    base = {a[23:4], 4'h0};
    ack_mode = 0;
    predict(a, miss);
    check("directed_predict_miss", miss, 1'b1);
    ready_q.push_back(a);
    wr_cyc = -1; rdy_cyc = -1; nacks = 0;
    wline = '0; wfa = '0;
    for (int k = 0; k < 4; k++) seen[k] = '0;
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = a;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_req && mem_ack && nacks < 4) begin seen[nacks] = mem_addr; nacks++; end
      if (wr && wr_cyc < 0) begin wr_cyc = n; wline = line; wfa = fill_addr; end
      if (cpu_ready) begin rdy_cyc = n; break; end
      @(posedge clk); #1;
      if (churn && n + 1 == 2) cpu_addr = 24'h0FFFF0;
      if (churn && n + 1 == 4) cpu_addr = a;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int k = 0; k < 4; k++) check("dir_mem_addr", seen[k], base + 24'(4*k));
    check("dir_wr_cycle", 152'(wr_cyc), 152'(5));
    check("dir_ready_cycle", 152'(rdy_cyc), 152'(6));
    check("dir_line", wline, exp_line);
    check("dir_fill_addr", wfa, base);
  endtask

  task automatic reset_mid_fill(input logic [23:0] a);
    logic [23:0] base;
    base = {a[23:4], 4'h0};
    ack_mode = 0;
    fill_q.push_back({base, line_of(base)});
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = a;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr", wr, 1'b0);
    check("rst_line", line, 128'd0);
    cpu_req = 1'b0;
    void'(fill_q.pop_back());
    tb_beats = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_access(a, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [14:0] tags[4];
    logic [23:0] a;
    bit          miss;
    tags[0] = 15'h0000; tags[1] = 15'h0001; tags[2] = 15'h02A5; tags[3] = 15'h7FFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cpu_ready", cpu_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_mem_addr", mem_addr, 24'h0);
    check("reset_fill_addr", fill_addr, 24'h0);
    check("reset_line", line, 128'h0);
    check("reset_wr", wr, 1'b0);
    check("reset_fill_err", fill_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_access(24'h000120, 1'b0);
    predict(24'h000120, miss);
    check("hit_predict", miss, 1'b0);
    ready_q.push_back(24'h000120);
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = 24'h000120;
    @(negedge clk);
    check("hit_cpu_ready", cpu_ready, 1'b1);
    check("hit_mem_req", mem_req, 1'b0);
    check("hit_wr", wr, 1'b0);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    directed_miss(24'h012345, 1'b0, 128'h44444444_33333333_22222222_11111111);
    directed_miss(24'h0234A8, 1'b1, line_of(24'h0234A0));

    ack_mode = 1;
    do_access(24'h045670, 1'b0);
    do_access(24'h045674, 1'b0);

    reset_mid_fill(24'h03A5C4);

    for (int i = 0; i < 60; i++) begin
      ack_mode = $urandom_range(0, 2);
      a = {tags[$urandom_range(0, 3)], 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      do_access(a, $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

`ifdef DMC_FILL_TIMEOUT_EN
    begin
      bit got;
      int k;
      ack_mode = 3;
      allow_abort = 1'b1;
      got = 1'b0;
      @(posedge clk); #1;
      cpu_req  = 1'b1;
      cpu_addr = 24'h05B000;
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (fill_err) begin got = 1'b1; break; end
      end
      check("timeout_fill_err", got, 1'b1);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(negedge clk);
      check("timeout_mem_req_drop", mem_req, 1'b0);
      check("timeout_idle", busy, 1'b0);
      check("timeout_err_one_cycle", fill_err, 1'b0);
      allow_abort = 1'b0;
      ack_mode = 0;
    end
`endif

    repeat (10) @(posedge clk);
    check("fill_q_drained", 152'(fill_q.size()), 152'(0));
    check("ready_q_drained", 152'(ready_q.size()), 152'(0));
`ifndef DMC_FILL_TIMEOUT_EN
    check("no_fill_err", 152'(err_seen), 152'(0));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/dmc_line_filler.md
Name: dmc_line_filler

Overview:
- Miss-handling and line-fill controller for the 32-line x 16-byte direct-mapped cache.
- Watches the CPU request and the cache hit flag. On a miss, fetches the 16-byte line from backing memory as four 32-bit beats and assembles it. Then writes it into the cache with a one-cycle write strobe, and releases the CPU once the line hits.
- Sits between the CPU fetch port, the cache line-write port (line, wr, fill address) and the flash/SRAM read interface.

Parameters:
- AW, 24, byte address width (matches cache A[23:0]).
- TIMEOUT, 255, max idle cycles between memory beats before abort (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU read request valid.
- cpu_addr  input  AW  CPU byte address.
- hit  input  1  cache hit flag for cpu_addr.
- cpu_ready  output  1  request served from cache this cycle.
- busy  output  1  fill in progress.
- mem_req  output  1  memory beat request, held until mem_ack.
- mem_addr  output  AW  word-aligned beat address.
- mem_ack  input  1  beat accepted; mem_rdata valid the same cycle.
- mem_rdata  input  32  beat data.
- fill_addr  output  AW  line base address to the cache A port during a write.
- line  output  128  assembled line.
- wr  output  1  one-cycle cache write strobe.
- fill_err  output  1  one-cycle pulse on fill abort.

Behaviour:
- States: IDLE, FETCH, WRITE.
- Reset values (asynchronous):
  - State = IDLE; beat counter = 0; line buffer = 0; base register = 0.
  - All outputs are 0: cpu_ready, busy, mem_req, mem_addr, fill_addr, line, wr, fill_err.
- cpu_ready = (state==IDLE) & cpu_req & hit. It is combinational and never asserted outside IDLE.
- IDLE:
  - cpu_req & !hit: latch base = {cpu_addr[AW-1:4], 4'h0}, beat = 0, go to FETCH.
  - !cpu_req: stay in IDLE.
- FETCH:
  - mem_req = 1, mem_addr = base + {beat, 2'b00}, busy = 1.
  - On each mem_ack: line buffer[32*beat +: 32] <= mem_rdata and beat <= beat+1. Beat 0 is the lowest word (little-endian).
  - mem_ack with beat==3 goes to WRITE. mem_req drops in the following cycle.
  - mem_ack while mem_req=0 is ignored.
- WRITE: one cycle; wr = 1, fill_addr = base, line = buffer, busy = 1. Then go to IDLE.
  - The cache captures the line at this edge, so hit is true for the same address in the next IDLE cycle.
- Miss latency with mem_ack every cycle: req at cycle 0 -> FETCH cycles 1-4 -> WRITE cycle 5 -> cpu_ready cycle 6.
- cpu_addr/cpu_req changes during FETCH/WRITE are ignored; the latched base is used.
  - If cpu_req is withdrawn mid-fill, the fill still completes and writes the line.
- fill_addr holds base outside WRITE. line always reflects the buffer. wr is never asserted for more than one consecutive cycle.
- Reset mid-fill: return to IDLE immediately. Partial beats are discarded, no wr, mem_req drops asynchronously.
- Beat-address wrap: base is line-aligned, so beat addresses never cross a 16-byte boundary.

Optional Feature:
- Macro: DMC_FILL_TIMEOUT_EN.
- Enabled:
  - An 8-bit watchdog counter clears on entry to FETCH and on every mem_ack, and increments each FETCH cycle without mem_ack.
  - When the counter reaches TIMEOUT: drop mem_req, pulse fill_err for 1 cycle, go to IDLE, no wr.
  - The CPU will re-miss and retry.
- Disabled: no counter; FETCH waits indefinitely; fill_err tied to 0.

Test Plan:
- Hit path: hit=1, cpu_req=1, cpu_addr=0x000120 -> cpu_ready=1 same cycle, mem_req stays 0, wr stays 0.
- Miss fill, back-to-back acks, cpu_addr=0x012345:
  - mem_addr sequence 0x012340, 0x012344, 0x012348, 0x01234C.
  - rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - wr pulses at cycle 5 with line=0x44444444_33333333_22222222_11111111 and fill_addr=0x012340.
  - cpu_ready at cycle 6.
- Stalled memory: mem_ack only every 3rd cycle -> mem_req and mem_addr held stable between acks; exactly one wr; line correct.
- Address churn: cpu_addr changed to 0x0FFFF0 during FETCH -> fill_addr remains the original base; no second fill starts until back in IDLE.
- Reset mid-fill: rst_n low after 2 beats -> mem_req=0 and busy=0 immediately, no wr; the next miss restarts at beat 0.
- With DMC_FILL_TIMEOUT_EN, TIMEOUT=8, mem_ack never asserted -> fill_err pulses 1 cycle, mem_req drops, wr never asserted, state returns to IDLE.
